// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// Used by imem_load_counter and imem_boot_loader.
package imem_pkg;

  localparam int unsigned IMEM_WORDS = 256;
  localparam logic [31:0] IMEM_NOP   = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_ERROR
  } imem_ld_state_e;

endpackage

// File: rtl/imem_load_counter.sv
// Word counter with full detect for the boot loader.
// IMEM_CHECKSUM_EN adds a modulo-2^32 sum of written words.
module imem_load_counter
  import imem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = IMEM_WORDS,
  parameter int unsigned ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              inc_i,
`ifdef IMEM_CHECKSUM_EN
  input  logic [31:0]       data_i,
  output logic [31:0]       sum_o,
`endif
  output logic [ADDR_W:0]   cnt_o,
  output logic              full_o
);

  logic [ADDR_W:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + (ADDR_W+1)'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == (ADDR_W+1)'(MEM_WORDS));

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
    end else if (inc_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o = sum_q;
`endif

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program image into instruction memory, then releases the core.
// Define IMEM_CHECKSUM_EN to treat the last beat as an image checksum.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = IMEM_WORDS,
  parameter int unsigned ADDR_W    = $clog2(MEM_WORDS),
  parameter logic [31:0] NOP_INSTR = IMEM_NOP
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              load_valid_i,
  input  logic [31:0]       load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  input  logic [31:0]       fetch_addr_i,
  output logic [31:0]       fetch_instr_o,
  output logic              core_run_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   words_loaded_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  imem_ld_state_e state_q, state_n;
  logic           ready_q, run_q, err_q;
  logic           accept, wr, ovf, sum_ok, full;
  logic [ADDR_W:0] cnt;

  assign accept = load_valid_i && ready_q;

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] sum;
  logic        prog;

  assign prog   = accept && !load_last_i;
  assign ovf    = prog && full;
  assign wr     = prog && !full;
  assign sum_ok = (load_data_i == sum);
`else
  assign ovf    = accept && full;
  assign wr     = accept && !full;
  assign sum_ok = 1'b1;
`endif

  imem_load_counter #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (start_i),
    .inc_i  (wr),
`ifdef IMEM_CHECKSUM_EN
    .data_i (load_data_i),
    .sum_o  (sum),
`endif
    .cnt_o  (cnt),
    .full_o (full)
  );

  // accept already implies LOAD; overflow outranks the last flag
  always_comb begin
    state_n = state_q;
    if (start_i) begin
      state_n = ST_LOAD;
    end else if (ovf) begin
      state_n = ST_ERROR;
    end else if (accept && load_last_i) begin
      state_n = sum_ok ? ST_RUN : ST_ERROR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      ready_q <= (state_n == ST_LOAD);
      run_q   <= (state_n == ST_RUN);
      err_q   <= (state_n == ST_ERROR);
    end
  end

  logic in_range;
  logic unused_lsb;

  assign in_range   = ~|fetch_addr_i[31:ADDR_W+2];
  assign unused_lsb = ^fetch_addr_i[1:0];

  assign load_ready_o   = ready_q;
  assign core_run_o     = run_q;
  assign load_err_o     = err_q;
  assign words_loaded_o = cnt;
  assign mem_we_o       = wr;
  assign mem_wdata_o    = wr ? load_data_i : '0;
  assign mem_addr_o     = run_q ? fetch_addr_i[ADDR_W+1:2]
                                : cnt[ADDR_W-1:0];
  assign fetch_instr_o  = (run_q && in_range) ? mem_rdata_i
                                              : NOP_INSTR;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a behavioural memory.
// Build with +define+IMEM_CHECKSUM_EN to exercise the checksum mode.
module tb_imem_boot_loader;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, lvalid, llast, lready;
  logic [31:0] ldata, faddr, finstr;
  logic        run, err, we;
  logic [8:0]  words;
  logic [7:0]  maddr;
  logic [31:0] wdata, rdata;

  logic [31:0] mem [0:255];
  logic [7:0]  wlog [$];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .load_valid_i   (lvalid),
    .load_data_i    (ldata),
    .load_last_i    (llast),
    .load_ready_o   (lready),
    .fetch_addr_i   (faddr),
    .fetch_instr_o  (finstr),
    .core_run_o     (run),
    .load_err_o     (err),
    .words_loaded_o (words),
    .mem_we_o       (we),
    .mem_addr_o     (maddr),
    .mem_wdata_o    (wdata),
    .mem_rdata_i    (rdata)
  );

  assign rdata = mem[maddr];

  always @(posedge clk) begin
    if (we) begin
      mem[maddr] <= wdata;
      wlog.push_back(maddr);
    end
  end

  typedef struct {
    logic        s, v, l;
    logic [31:0] d, fa;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        rdy, run;
    logic [31:0] ins;
    logic [8:0]  wl;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(
    input logic s, v, l, input logic [31:0] d, fa,
    input logic e_we, input logic [7:0] e_addr,
    input logic [31:0] e_wd, input logic e_rdy, e_run,
    input logic [31:0] e_ins, input logic [8:0] e_wl);
    vec_t r;
    r.s = s; r.v = v; r.l = l; r.d = d; r.fa = fa;
    r.we = e_we; r.addr = e_addr; r.wd = e_wd;
    r.rdy = e_rdy; r.run = e_run; r.ins = e_ins; r.wl = e_wl;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string n, input logic [31:0] a, e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic cyc(input logic s, v, input logic [31:0] d,
                     input logic l);
    @(negedge clk);
    start = s; lvalid = v; ldata = d; llast = l;
    #1;
  endtask

  logic [31:0] prog [13];

  initial begin
    prog = '{32'h00a00093, 32'h01400113, 32'h40510133, 32'h002081b3,
             32'h00310233, 32'h404202b3, 32'h00500313, 32'h006303b3,
             32'h00738433, 32'h008404b3, 32'h00948533, 32'h00a505b3,
             32'hffc0006f};
    rst_n = 1'b0; start = 0; lvalid = 0; llast = 0;
    ldata = '0; faddr = 32'h8;
    #12;
    chk("rst_ready", lready, 0);
    chk("rst_run",   run,    0);
    chk("rst_err",   err,    0);
    chk("rst_we",    we,     0);
    chk("rst_addr",  maddr,  0);
    chk("rst_wdata", wdata,  0);
    chk("rst_words", words,  0);
    chk("rst_instr", finstr, NOP);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      faddr = $urandom;
      cyc(0, 0, 0, 0);
      chk("idle_instr", finstr, NOP);
      chk("idle_run",   run,    0);
      chk("idle_ready", lready, 0);
    end

`ifndef IMEM_CHECKSUM_EN
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NOP, 0);
    for (int k = 0; k < 13; k++)
      add(0, 1, k == 12, prog[k], 0, 1, 8'(k), prog[k], 1, 0, NOP, 9'(k));
    add(0, 0, 0, 0, 32'h8,  0, 2,  0, 0, 1, 32'h40510133, 13);
    add(0, 0, 0, 0, 32'h0,  0, 0,  0, 0, 1, prog[0], 13);
    add(0, 0, 0, 0, 32'h30, 0, 12, 0, 0, 1, prog[12], 13);
    add(0, 0, 0, 0, 32'hb,  0, 2,  0, 0, 1, 32'h40510133, 13);
    add(0, 0, 0, 0, 32'h400, 0, 0, 0, 0, 1, NOP, 13);
    add(0, 0, 0, 0, 32'hfffffff8, 0, 8'hfe, 0, 0, 1, NOP, 13);
    add(1, 0, 0, 0, 32'h8,  0, 2,  0, 0, 1, 32'h40510133, 13);
    add(0, 0, 0, 0, 32'h8,  0, 0,  0, 1, 0, NOP, 0);

    foreach (tbl[i]) begin
      faddr = tbl[i].fa;
      cyc(tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].l);
      chk($sformatf("v%0d_we", i),    we,     tbl[i].we);
      chk($sformatf("v%0d_addr", i),  maddr,  tbl[i].addr);
      chk($sformatf("v%0d_wdata", i), wdata,  tbl[i].wd);
      chk($sformatf("v%0d_ready", i), lready, tbl[i].rdy);
      chk($sformatf("v%0d_run", i),   run,    tbl[i].run);
      chk($sformatf("v%0d_instr", i), finstr, tbl[i].ins);
      chk($sformatf("v%0d_words", i), words,  tbl[i].wl);
    end
    for (int k = 0; k < 13; k++)
      chk($sformatf("mem%0d", k), mem[k], prog[k]);

    // valid toggling every other cycle, six beats
    begin
      int base;
      base = wlog.size();
      for (int i = 0; i < 12; i++)
        cyc(0, i % 2 == 0, 32'h1000 + 32'(i / 2), i == 10);
      cyc(0, 0, 0, 0);
      chk("tog_nwr", wlog.size() - base, 6);
      for (int j = 0; j < 6; j++) begin
        chk($sformatf("tog_a%0d", j), wlog[base + j], 8'(j));
        chk($sformatf("tog_d%0d", j), mem[j], 32'h1000 + 32'(j));
      end
      chk("tog_words", words, 6);
      chk("tog_run",   run,   1);
    end

    // start coinciding with an accepted beat
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'hb0 + 32'(i), 0);
    cyc(1, 1, 32'hbeef0003, 0);
    chk("sb_we",   we,    1);
    chk("sb_addr", maddr, 3);
    cyc(0, 0, 0, 0);
    chk("sb_words", words,  0);
    chk("sb_ready", lready, 1);
    chk("sb_mem3",  mem[3], 32'hbeef0003);

    // overflow: 257 beats, last flagged on the 257th
    for (int i = 0; i < 257; i++) begin
      cyc(0, 1, 32'ha0000000 + 32'(i), i == 256);
      if (i == 256) chk("ovf_we", we, 0);
    end
    cyc(0, 0, 0, 0);
    chk("ovf_err",    err,      1);
    chk("ovf_run",    run,      0);
    chk("ovf_ready",  lready,   0);
    chk("ovf_words",  words,    256);
    chk("ovf_mem0",   mem[0],   32'ha0000000);
    chk("ovf_mem255", mem[255], 32'ha00000ff);
    cyc(1, 0, 0, 0);
    chk("clr_err_hold", err, 1);
    cyc(0, 0, 0, 0);
    chk("clr_err",   err,    0);
    chk("clr_ready", lready, 1);
    chk("clr_words", words,  0);

    // reset in the middle of a load
    cyc(0, 1, 32'hc0de0000, 0);
    cyc(0, 0, 0, 0);
    chk("mid_words1", words, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_ready", lready, 0);
    chk("mid_words", words,  0);
    chk("mid_mem0",  mem[0], 32'hc0de0000);
    @(negedge clk);
    rst_n = 1'b1;
`else
    for (int t = 0; t < 2; t++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 1, 1, 0);
      cyc(0, 1, 2, 0);
      cyc(0, 1, 3, 0);
      cyc(0, 1, 32'(6 + t), 1);
      chk($sformatf("cs%0d_we", t), we, 0);
      cyc(0, 0, 0, 0);
      chk($sformatf("cs%0d_run", t),   run,   t == 0);
      chk($sformatf("cs%0d_err", t),   err,   t == 1);
      chk($sformatf("cs%0d_words", t), words, 3);
      chk($sformatf("cs%0d_mem2", t),  mem[2], 3);
    end
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("cs_clr_err",   err,    0);
    chk("cs_clr_ready", lready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
